// File: rtl/kernel_feeder_if.sv
// Sample-in / pair-out bundle between the sample source, kernel_feeder and the multiply-reduce stage.
// The slave modport is the feeder's view; the master modport is the surrounding logic's view.
interface kernel_feeder_if #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned KERNEL_SIZE = 5
);
    logic                              kernel_feeder_ready_in;
    logic                              kernel_feeder_valid_in;
    logic [DATA_WIDTH-1:0]             kernel_feeder_data_in;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] kernel_feeder_weights_in;
    logic                              kernel_feeder_flush_in;
    logic                              kernel_feeder_ready_out;
    logic                              kernel_feeder_valid_out;
    logic [DATA_WIDTH-1:0]             kernel_feeder_dataa_out;
    logic [DATA_WIDTH-1:0]             kernel_feeder_datab_out;
    logic                              kernel_feeder_last_out;

    modport slave (
        input  kernel_feeder_valid_in,
        input  kernel_feeder_data_in,
        input  kernel_feeder_weights_in,
        input  kernel_feeder_flush_in,
        input  kernel_feeder_ready_out,
        output kernel_feeder_ready_in,
        output kernel_feeder_valid_out,
        output kernel_feeder_dataa_out,
        output kernel_feeder_datab_out,
        output kernel_feeder_last_out
    );

    modport master (
        output kernel_feeder_valid_in,
        output kernel_feeder_data_in,
        output kernel_feeder_weights_in,
        output kernel_feeder_flush_in,
        output kernel_feeder_ready_out,
        input  kernel_feeder_ready_in,
        input  kernel_feeder_valid_out,
        input  kernel_feeder_dataa_out,
        input  kernel_feeder_datab_out,
        input  kernel_feeder_last_out
    );
endinterface

// File: rtl/kernel_feeder.sv
// Sliding-window feeder: holds KERNEL_SIZE samples and streams (sample, weight) pairs,
// one window per accepted sample once the window has filled (stride 1).
module kernel_feeder #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned KERNEL_SIZE = 5
) (
    input  logic           clk,
    input  logic           rst,
    kernel_feeder_if.slave bus
);
    localparam int unsigned CW = $clog2(KERNEL_SIZE + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(KERNEL_SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {FILL, EMIT, SLIDE} state_e;

    state_e                               state_q;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_q;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_d;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weights_c;
    logic [CW-1:0]                        fill_q, fill_d;
    logic [CW-1:0]                        idx_q, idx_d;
    logic                                 ready_q, valid_q, last_q;
    logic [DATA_WIDTH-1:0]                dataa_q, datab_q;
    logic                                 in_hs_c, out_hs_c;

    // Index 0 holds the oldest sample; a new sample enters at the top.
    assign weights_c = bus.kernel_feeder_weights_in;
    assign win_d     = {bus.kernel_feeder_data_in, win_q[KERNEL_SIZE-1:1]};
    assign fill_d    = fill_q + 1'b1;
    assign idx_d     = idx_q + 1'b1;
    assign in_hs_c   = bus.kernel_feeder_valid_in && ready_q;
    assign out_hs_c  = valid_q && bus.kernel_feeder_ready_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            dataa_q <= '0;
            datab_q <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
        end else if (bus.kernel_feeder_flush_in) begin
            state_q <= FILL;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fill_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_hs_c) begin
                        win_q  <= win_d;
                        fill_q <= fill_d;
                        if (fill_d == FULL_CNT) begin
                            state_q <= EMIT;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            last_q  <= 1'b0;
                            dataa_q <= win_d[0];
                            datab_q <= weights_c[0];
                            idx_q   <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_hs_c) begin
                        if (idx_q < LAST_IDX) begin
                            idx_q   <= idx_d;
                            dataa_q <= win_q[idx_d];
                            datab_q <= weights_c[idx_d];
                            last_q  <= (idx_d == LAST_IDX);
                        end else begin
                            state_q <= SLIDE;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                SLIDE: begin
                    // One new sample yields one full window starting on the next cycle.
                    if (in_hs_c) begin
                        win_q   <= win_d;
                        state_q <= EMIT;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        dataa_q <= win_d[0];
                        datab_q <= weights_c[0];
                        idx_q   <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.kernel_feeder_ready_in  = ready_q;
    assign bus.kernel_feeder_valid_out = valid_q;
    assign bus.kernel_feeder_dataa_out = dataa_q;
    assign bus.kernel_feeder_datab_out = datab_q;
    assign bus.kernel_feeder_last_out  = last_q;
endmodule

// File: tb/tb_kernel_feeder.sv
// Directed bench for kernel_feeder: fill, slide, backpressure, flush, mid-run reset, extreme values.
module tb_kernel_feeder;
    localparam int unsigned DW = 12;
    localparam int unsigned K  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kernel_feeder_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) bus ();
    kernel_feeder #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_a [K];
    logic [DW-1:0] got_b [K];
    logic          got_last [K];
    int            got_cycles, got_rdy_hi, got_hold_err;
    logic [15:0]   pat = 16'b0110_1001_1100_1010;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and wait (bounded) for it to be accepted.
    task automatic send(input logic [DW-1:0] v);
        bus.kernel_feeder_valid_in = 1'b1;
        bus.kernel_feeder_data_in  = v;
        for (int n = 0; n < 100; n++) begin
            if (bus.kernel_feeder_ready_in === 1'b1) begin
                step();
                bus.kernel_feeder_valid_in = 1'b0;
                return;
            end
            step();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout ready_in=%0b required 1", bus.kernel_feeder_ready_in);
        bus.kernel_feeder_valid_in = 1'b0;
    endtask

    // Gather one window of K pairs; bp selects patterned ready_out.
    task automatic collect(input bit bp);
        int n = 0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [DW-1:0] pa = '0, pb = '0;
        got_cycles = 0; got_rdy_hi = 0; got_hold_err = 0;
        for (int c = 0; c < 200 && n < int'(K); c++) begin
            bus.kernel_feeder_ready_out = bp ? pat[4'(c)] : 1'b1;
            if (pv && !pr && (bus.kernel_feeder_valid_out !== 1'b1 || bus.kernel_feeder_dataa_out !== pa ||
                              bus.kernel_feeder_datab_out !== pb || bus.kernel_feeder_last_out !== pl))
                got_hold_err++;
            if (bus.kernel_feeder_ready_in !== 1'b0) got_rdy_hi++;
            pv = bus.kernel_feeder_valid_out; pr = bus.kernel_feeder_ready_out;
            pa = bus.kernel_feeder_dataa_out; pb = bus.kernel_feeder_datab_out; pl = bus.kernel_feeder_last_out;
            if (bus.kernel_feeder_valid_out === 1'b1 && bus.kernel_feeder_ready_out === 1'b1) begin
                got_a[n] = bus.kernel_feeder_dataa_out;
                got_b[n] = bus.kernel_feeder_datab_out;
                got_last[n] = bus.kernel_feeder_last_out;
                n++;
            end
            got_cycles++;
            step();
        end
        bus.kernel_feeder_ready_out = 1'b1;
        if (n < int'(K)) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout pairs=%0d required %0d", n, K);
        end
    endtask

    task automatic set_weights_seq();
        for (int i = 0; i < int'(K); i++) bus.kernel_feeder_weights_in[i*DW +: DW] = DW'(i + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.kernel_feeder_valid_in = 1'b0; bus.kernel_feeder_data_in = '0;
        bus.kernel_feeder_flush_in = 1'b0; bus.kernel_feeder_ready_out = 1'b0;
        set_weights_seq();
        step(); step();
        checks++; if (bus.kernel_feeder_ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in got %0b want 1", bus.kernel_feeder_ready_in); end
        checks++; if (bus.kernel_feeder_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %0b want 0", bus.kernel_feeder_valid_out); end
        checks++; if (bus.kernel_feeder_dataa_out !== 12'h000) begin errors++; $display("FAIL reset_dataa got %h want 000", bus.kernel_feeder_dataa_out); end
        checks++; if (bus.kernel_feeder_datab_out !== 12'h000) begin errors++; $display("FAIL reset_datab got %h want 000", bus.kernel_feeder_datab_out); end
        checks++; if (bus.kernel_feeder_last_out !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", bus.kernel_feeder_last_out); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_first_window();
        int sum = 0;
        bus.kernel_feeder_ready_out = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            send(DW'(v));
            checks++; if (bus.kernel_feeder_valid_out !== 1'b0) begin errors++; $display("FAIL fill_valid_early s=%0d got %0b want 0", v, bus.kernel_feeder_valid_out); end
        end
        send(12'd5);
        checks++; if (bus.kernel_feeder_valid_out !== 1'b1) begin errors++; $display("FAIL first_latency valid got %0b want 1", bus.kernel_feeder_valid_out); end
        checks++; if (bus.kernel_feeder_ready_in !== 1'b0) begin errors++; $display("FAIL first_ready_in got %0b want 0", bus.kernel_feeder_ready_in); end
        collect(1'b0);
        for (int i = 0; i < int'(K); i++) begin
            checks++; if (got_a[i] !== DW'(i + 1) || got_b[i] !== DW'(i + 1) || got_last[i] !== (i == int'(K) - 1)) begin
                errors++; $display("FAIL first_pair%0d got (%0d,%0d,%0b) want (%0d,%0d,%0b)", i, got_a[i], got_b[i], got_last[i], i + 1, i + 1, i == int'(K) - 1); end
            sum += int'(got_a[i]) * int'(got_b[i]);
        end
        checks++; if (sum !== 55) begin errors++; $display("FAIL first_sum got %0d want 55", sum); end
        checks++; if (got_cycles !== 5) begin errors++; $display("FAIL first_cycles got %0d want 5", got_cycles); end
        checks++; if (got_rdy_hi !== 0) begin errors++; $display("FAIL first_ready_in_emit got %0d want 0", got_rdy_hi); end
        checks++; if (bus.kernel_feeder_valid_out !== 1'b0 || bus.kernel_feeder_ready_in !== 1'b1) begin
            errors++; $display("FAIL first_after valid/ready got %0b/%0b want 0/1", bus.kernel_feeder_valid_out, bus.kernel_feeder_ready_in); end
    endtask

    task automatic test_slide();
        int exp_sum [2] = '{70, 85};
        for (int w = 0; w < 2; w++) begin
            int sum = 0;
            send(DW'(6 + w));
            collect(1'b0);
            for (int i = 0; i < int'(K); i++) begin
                checks++; if (got_a[i] !== DW'(2 + w + i) || got_b[i] !== DW'(i + 1) || got_last[i] !== (i == int'(K) - 1)) begin
                    errors++; $display("FAIL slide%0d_pair%0d got (%0d,%0d,%0b) want (%0d,%0d,%0b)", w, i, got_a[i], got_b[i], got_last[i], 2 + w + i, i + 1, i == int'(K) - 1); end
                sum += int'(got_a[i]) * int'(got_b[i]);
            end
            checks++; if (sum !== exp_sum[w]) begin errors++; $display("FAIL slide%0d_sum got %0d want %0d", w, sum, exp_sum[w]); end
        end
    endtask

    task automatic test_backpressure();
        send(12'd8);
        collect(1'b1);
        for (int i = 0; i < int'(K); i++) begin
            checks++; if (got_a[i] !== DW'(4 + i) || got_b[i] !== DW'(i + 1) || got_last[i] !== (i == int'(K) - 1)) begin
                errors++; $display("FAIL bp_pair%0d got (%0d,%0d,%0b) want (%0d,%0d,%0b)", i, got_a[i], got_b[i], got_last[i], 4 + i, i + 1, i == int'(K) - 1); end
        end
        checks++; if (got_hold_err !== 0) begin errors++; $display("FAIL bp_hold got %0d violations want 0", got_hold_err); end
        checks++; if (got_rdy_hi !== 0) begin errors++; $display("FAIL bp_ready_in got %0d high cycles want 0", got_rdy_hi); end
        checks++; if (got_cycles <= 5) begin errors++; $display("FAIL bp_stalls got %0d cycles want >5", got_cycles); end
        checks++; if (bus.kernel_feeder_ready_in !== 1'b1) begin errors++; $display("FAIL bp_after ready_in got %0b want 1", bus.kernel_feeder_ready_in); end
    endtask

    task automatic test_flush();
        bus.kernel_feeder_ready_out = 1'b1;
        send(12'd9);
        step(); step();
        checks++; if (bus.kernel_feeder_dataa_out !== 12'd7 || bus.kernel_feeder_datab_out !== 12'd3) begin
            errors++; $display("FAIL flush_pre_pair got (%0d,%0d) want (7,3)", bus.kernel_feeder_dataa_out, bus.kernel_feeder_datab_out); end
        bus.kernel_feeder_flush_in = 1'b1;
        bus.kernel_feeder_valid_in = 1'b1;
        bus.kernel_feeder_data_in  = 12'd99;
        step();
        bus.kernel_feeder_flush_in = 1'b0;
        bus.kernel_feeder_valid_in = 1'b0;
        checks++; if (bus.kernel_feeder_valid_out !== 1'b0 || bus.kernel_feeder_ready_in !== 1'b1 || bus.kernel_feeder_last_out !== 1'b0) begin
            errors++; $display("FAIL flush_after valid/ready/last got %0b/%0b/%0b want 0/1/0", bus.kernel_feeder_valid_out, bus.kernel_feeder_ready_in, bus.kernel_feeder_last_out); end
        for (int v = 10; v <= 13; v++) begin
            send(DW'(v));
            checks++; if (bus.kernel_feeder_valid_out !== 1'b0) begin errors++; $display("FAIL flush_refill_valid s=%0d got %0b want 0", v, bus.kernel_feeder_valid_out); end
        end
        send(12'd14);
        collect(1'b0);
        for (int i = 0; i < int'(K); i++) begin
            checks++; if (got_a[i] !== DW'(10 + i) || got_b[i] !== DW'(i + 1)) begin
                errors++; $display("FAIL flush_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_a[i], got_b[i], 10 + i, i + 1); end
        end
    endtask

    task automatic test_reset_mid();
        bus.kernel_feeder_ready_out = 1'b1;
        send(12'd15);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.kernel_feeder_ready_in !== 1'b1 || bus.kernel_feeder_valid_out !== 1'b0 || bus.kernel_feeder_last_out !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl ready/valid/last got %0b/%0b/%0b want 1/0/0", bus.kernel_feeder_ready_in, bus.kernel_feeder_valid_out, bus.kernel_feeder_last_out); end
        checks++; if (bus.kernel_feeder_dataa_out !== 12'h000 || bus.kernel_feeder_datab_out !== 12'h000) begin
            errors++; $display("FAIL rstmid_data got (%h,%h) want (000,000)", bus.kernel_feeder_dataa_out, bus.kernel_feeder_datab_out); end
        for (int v = 20; v <= 23; v++) begin
            send(DW'(v));
            checks++; if (bus.kernel_feeder_valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_refill_valid s=%0d got %0b want 0", v, bus.kernel_feeder_valid_out); end
        end
        send(12'd24);
        collect(1'b0);
        for (int i = 0; i < int'(K); i++) begin
            checks++; if (got_a[i] !== DW'(20 + i) || got_b[i] !== DW'(i + 1)) begin
                errors++; $display("FAIL rstmid_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_a[i], got_b[i], 20 + i, i + 1); end
        end
    endtask

    task automatic test_extremes();
        logic [DW-1:0] sx [6] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
        logic [DW-1:0] wx [5] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        rst = 1'b1;
        for (int i = 0; i < int'(K); i++) bus.kernel_feeder_weights_in[i*DW +: DW] = wx[i];
        step();
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            bus.kernel_feeder_valid_in = 1'b0;
            for (int g = 0; g < 2; g++) begin
                step();
                if (s < 5) begin
                    checks++; if (bus.kernel_feeder_valid_out !== 1'b0) begin errors++; $display("FAIL ext_gap s=%0d got valid %0b want 0", s, bus.kernel_feeder_valid_out); end
                end
            end
            send(sx[s]);
            if (s >= 4) begin
                collect(1'b0);
                for (int i = 0; i < int'(K); i++) begin
                    checks++; if (got_a[i] !== sx[s - 4 + i] || got_b[i] !== wx[i] || got_last[i] !== (i == int'(K) - 1)) begin
                        errors++; $display("FAIL ext_w%0d_pair%0d got (%h,%h,%0b) want (%h,%h,%0b)", s - 4, i, got_a[i], got_b[i], got_last[i], sx[s - 4 + i], wx[i], i == int'(K) - 1); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_slide();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
